// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit
//   Dynamic branch predictor: a table of saturating counters indexed by PC.
//   IF side reads a taken/not-taken prediction combinationally; ID side
//   takes resolutions, raises flush/mispredict and trains the table through
//   a one-deep pending-update register (one table write per cycle).
//
// Ports
//   clk, arst_n          clock / synchronous active-low reset
//   ready                table initialised, predictions valid
//   pred_pc, pred_taken  IF-stage lookup (combinational)
//   res_*                ID-stage resolution (valid, jump, pc, carried pred, outcome)
//   flush, mispredict    combinational control to the pipeline
//   perf_branches, perf_mispredicts  saturating event counters
//                                    (present only with BP_PERF_CNT_EN defined)
//
// Optional feature macro: BP_PERF_CNT_EN
module branch_predictor_unit #(
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int INDEX_LSB = 2
) (
    input  logic            clk,
    input  logic            arst_n,
    output logic            ready,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_is_jump,
    input  logic [PC_W-1:0] res_pc,
    input  logic            res_pred_taken,
    input  logic            res_taken,
    output logic            flush,
    output logic            mispredict
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WNT     = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BHT_DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic             pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic [CNT_W-1:0] bht_q [BHT_DEPTH];

    logic [IDX_W-1:0] pidx, ridx;
    logic [CNT_W-1:0] pred_cnt, old_cnt, new_cnt;
    logic             train;

    assign pidx = pred_pc[INDEX_LSB +: IDX_W];
    assign ridx = res_pc[INDEX_LSB +: IDX_W];

    // Only the index bits of the PCs matter; the rest are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, res_pc};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == S_INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == IDX_LAST) state_d = S_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = (state_q == S_RUN);
    end

    // ---------------- Prediction ----------------
    // The pending entry is newer than the table, so it wins on an index match.
    always_comb begin
        pred_cnt = (pend_vld_q && pend_idx_q == pidx) ? pend_val_q : bht_q[pidx];
        pred_taken = ready & pred_cnt[CNT_W-1];
    end

    // ---------------- Resolution ----------------
    assign mispredict = res_valid & ~res_is_jump & (res_taken != res_pred_taken);
    assign flush      = res_valid & (res_is_jump | (res_taken != res_pred_taken));
    assign train      = ready & res_valid & ~res_is_jump;

    // Back-to-back updates to one index chain through the pending register.
    always_comb begin
        old_cnt = (pend_vld_q && pend_idx_q == ridx) ? pend_val_q : bht_q[ridx];
        if (res_taken) new_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + 1'b1;
        else           new_cnt = (old_cnt == '0)      ? old_cnt : old_cnt - 1'b1;
        pend_vld_d = train;
        pend_idx_d = train ? ridx    : pend_idx_q;
        pend_val_d = train ? new_cnt : pend_val_q;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            pend_val_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            pend_val_q <= pend_val_d;
        end
    end

    // Single write port: init walk in INIT, pending commit in RUN.
    // A reset edge writes nothing, which drops any pending update.
    always_ff @(posedge clk) begin
        if (arst_n) begin
            if (state_q == S_INIT)  bht_q[init_idx_q] <= WNT;
            else if (pend_vld_q)    bht_q[pend_idx_q] <= pend_val_q;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_mp_q;
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (res_valid && !res_is_jump && perf_br_q != '1) perf_br_q <= perf_br_q + 1'b1;
            if (mispredict && perf_mp_q != '1)                perf_mp_q <= perf_mp_q + 1'b1;
        end
    end
    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Self-checking bench for branch_predictor_unit (default parameters).
// Expected values are pushed to a scoreboard queue when stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_branch_predictor_unit;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        ready, pred_taken, flush, mispredict;
    logic [31:0] pred_pc = '0, res_pc = '0;
    logic        res_valid = 1'b0, res_is_jump = 1'b0, res_pred_taken = 1'b0, res_taken = 1'b0;

    branch_predictor_unit dut (
        .clk(clk), .arst_n(arst_n), .ready(ready),
        .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_is_jump(res_is_jump), .res_pc(res_pc),
        .res_pred_taken(res_pred_taken), .res_taken(res_taken),
        .flush(flush), .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    typedef struct { string n; logic [31:0] v; } exp_t;
    exp_t sb[$];
    exp_t e;
    int   n_run = 0, n_fail = 0;

    function automatic void push(string n, logic [31:0] v);
        exp_t x;
        x.n = n; x.v = v;
        sb.push_back(x);
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic pt, input logic jmp);
        res_valid = 1'b1; res_pc = pc; res_taken = tk; res_pred_taken = pt; res_is_jump = jmp;
        tick();
        res_valid = 1'b0; res_is_jump = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; res_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        for (int k = 0; k < 65; k++) begin
            pred_pc = $urandom;
            push("ready_after_release", 32'(k == 64));
            push("pred_during_init", 0);
            #1;
            e = sb.pop_front(); n_run++;
            if (ready !== e.v[0]) begin n_fail++; $display("FAIL %s cyc=%0d got=%b exp=%b", e.n, k, ready, e.v[0]); end
            e = sb.pop_front(); n_run++;
            if (k < 64 && pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s cyc=%0d got=%b exp=%b", e.n, k, pred_taken, e.v[0]); end
            if (k < 64) tick();
        end
        for (int i = 0; i < 64; i++) begin
            pred_pc = 32'(i) << 2;
            push("pred_after_init", 0);
            #1;
            e = sb.pop_front(); n_run++;
            if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s idx=%0d got=%b exp=%b", e.n, i, pred_taken, e.v[0]); end
        end
        tick();
    endtask

    task automatic test_train();
        resolve(32'h100, 1'b1, 1'b0, 1'b0);
        resolve(32'h100, 1'b1, 1'b1, 1'b0);
        pred_pc = 32'h100;
        for (int k = 0; k < 2; k++) begin
            push("train_0x100", 1);
            #1;
            e = sb.pop_front(); n_run++;
            if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s k=%0d got=%b exp=%b", e.n, k, pred_taken, e.v[0]); end
            tick();
        end
    endtask

    task automatic test_hysteresis();
        logic [31:0] pcs [2];
        logic        exp_seq [2][5];
        logic        dir_seq [2][5];
        pcs[0] = 32'h40;  // 5 taken -> 3; NT -> 2 (1); NT -> 1 (0)
        pcs[1] = 32'hC0;  // NT x3 saturates at 0; T -> 1 (0); T -> 2 (1)
        for (int s = 0; s < 5; s++) begin
            dir_seq[0][s] = 1'b1; exp_seq[0][s] = 1'b1;
        end
        dir_seq[1][0] = 1'b0; dir_seq[1][1] = 1'b0; dir_seq[1][2] = 1'b0; dir_seq[1][3] = 1'b1; dir_seq[1][4] = 1'b1;
        exp_seq[1][0] = 1'b0; exp_seq[1][1] = 1'b0; exp_seq[1][2] = 1'b0; exp_seq[1][3] = 1'b0; exp_seq[1][4] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 5; s++) begin
                resolve(pcs[p], dir_seq[p][s], 1'b0, 1'b0);
                pred_pc = pcs[p];
                push("hyst_seq", 32'(exp_seq[p][s]));
                #1;
                e = sb.pop_front(); n_run++;
                if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s pc=%h step=%0d got=%b exp=%b", e.n, pcs[p], s, pred_taken, e.v[0]); end
            end
        end
        for (int s = 0; s < 2; s++) begin
            resolve(32'h40, 1'b0, 1'b1, 1'b0);
            pred_pc = 32'h40;
            push("hyst_not_taken", 32'(s == 0));
            #1;
            e = sb.pop_front(); n_run++;
            if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s step=%0d got=%b exp=%b", e.n, s, pred_taken, e.v[0]); end
        end
        tick();
    endtask

    task automatic test_forwarding();
        resolve(32'h80, 1'b1, 1'b0, 1'b0);
        pred_pc = 32'h80;
        push("fwd_pending", 1);
        #1;
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
        pred_pc = 32'h84;
        push("fwd_other_idx", 0);
        #1;
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
        tick();
    endtask

    task automatic test_flush();
        // {valid, jump, pred, taken} -> {flush, mispredict}
        logic [3:0] stim [6];
        logic [1:0] expv [6];
        stim[0] = 4'b1001; expv[0] = 2'b11;
        stim[1] = 4'b1011; expv[1] = 2'b00;
        stim[2] = 4'b1010; expv[2] = 2'b11;
        stim[3] = 4'b1100; expv[3] = 2'b10;
        stim[4] = 4'b1111; expv[4] = 2'b10;
        stim[5] = 4'b0001; expv[5] = 2'b00;
        res_pc = 32'h3F0;
        for (int i = 0; i < 6; i++) begin
            {res_valid, res_is_jump, res_pred_taken, res_taken} = stim[i];
            push("flush_mispredict", 32'(expv[i]));
            #1;
            e = sb.pop_front(); n_run++;
            if ({flush, mispredict} !== e.v[1:0]) begin n_fail++; $display("FAIL %s case=%0d got=%b exp=%b", e.n, i, {flush, mispredict}, e.v[1:0]); end
            #1;
        end
        res_valid = 1'b0; res_is_jump = 1'b0;
        for (int i = 0; i < 3; i++) resolve(32'h30, 1'b1, 1'b0, 1'b1);
        tick();
        pred_pc = 32'h30;
        push("jump_no_train", 0);
        #1;
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
    endtask

    task automatic test_back_to_back();
        resolve(32'h10, 1'b1, 1'b0, 1'b0);  // A 1->2
        resolve(32'h14, 1'b1, 1'b0, 1'b0);  // B 1->2, A commits
        resolve(32'h10, 1'b1, 1'b1, 1'b0);  // A 2->3
        resolve(32'h10, 1'b0, 1'b1, 1'b0);  // A 3->2 (forwarded)
        pred_pc = 32'h10; push("b2b_A", 1); #1;
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
        pred_pc = 32'h14; push("b2b_B", 1); #1;
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
        resolve(32'h10, 1'b0, 1'b1, 1'b0);  // A 2->1
        pred_pc = 32'h10; push("b2b_A_down", 0); #1;
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
        tick();
    endtask

    task automatic test_alias_reset();
        int cyc;
        pred_pc = 32'h200; push("alias_0x200", 1); #1;
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
        // Reset lands together with a training resolution for 0x100.
        arst_n = 1'b0;
        res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b0; res_pred_taken = 1'b1;
        tick();
        arst_n = 1'b1;
        res_pc = 32'h2C; res_taken = 1'b1; res_pred_taken = 1'b0;
        pred_pc = 32'h100;
        push("ready_after_mid_reset", 0); push("pred_after_mid_reset", 0); push("flush_in_init", 3);
        #1;
        e = sb.pop_front(); n_run++;
        if (ready !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, ready, e.v[0]); end
        e = sb.pop_front(); n_run++;
        if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_run++;
        if ({flush, mispredict} !== e.v[1:0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, {flush, mispredict}, e.v[1:0]); end
        cyc = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            tick(); #1; cyc++;
        end
        res_valid = 1'b0;
        push("ready_timeout", 1); push("reinit_cycles", 64);
        e = sb.pop_front(); n_run++;
        if (ready !== e.v[0]) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.n, ready, e.v[0]); end
        e = sb.pop_front(); n_run++;
        if (cyc !== int'(e.v)) begin n_fail++; $display("FAIL %s got=%0d exp=%0d", e.n, cyc, e.v); end
        begin
            logic [31:0] pcs [4];
            pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h2C; pcs[3] = 32'h40;
            for (int i = 0; i < 4; i++) begin
                pred_pc = pcs[i]; push("pred_after_reinit", 0); #1;
                e = sb.pop_front(); n_run++;
                if (pred_taken !== e.v[0]) begin n_fail++; $display("FAIL %s pc=%h got=%b exp=%b", e.n, pcs[i], pred_taken, e.v[0]); end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_train();
        test_hysteresis();
        test_forwarding();
        test_flush();
        test_back_to_back();
        test_alias_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
